// File: rtl/vrf_pkg.sv
// Shared constants, state encoding and helpers for the vector write-back packer.
package vrf_pkg;

   localparam int unsigned DATA_WIDTH     = 16;
   localparam int unsigned REG_WIDTH      = 4;
   localparam int unsigned VMAX           = 8;
   localparam int unsigned VL_WIDTH       = $clog2(VMAX) + 1;
   localparam int unsigned LANE_IDX_WIDTH = (VMAX > 1) ? $clog2(VMAX) : 1;

   // Register 0 is hardwired to zero in the register file.
   localparam logic [REG_WIDTH-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCollect = 2'd1,
      StWrite   = 2'd2
   } vwb_state_e;

   // Limit a requested vector length to the number of physical lanes.
   function automatic logic [VL_WIDTH-1:0] clamp_vl(input logic [VL_WIDTH-1:0] vl);
      if (vl > VL_WIDTH'(VMAX)) begin
         return VL_WIDTH'(VMAX);
      end
      return vl;
   endfunction

endpackage

// File: rtl/vector_lane_shift_reg.sv
// Shadow vector register: one lane written per cycle by index, whole vector cleared on demand.
// Exposes the next-state view so the owner can capture the final lane in the same cycle.
module vector_lane_shift_reg #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned Lanes     = 8,
   parameter int unsigned IdxWidth  = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   input  logic                       wr_en_i,
   input  logic [IdxWidth-1:0]        wr_idx_i,
   input  logic [DataWidth-1:0]       wr_data_i,
   output logic [DataWidth*Lanes-1:0] vec_next_o
);

   logic [Lanes-1:0][DataWidth-1:0] lane_q, lane_d;

   // Clear has priority over a lane write.
   always_comb begin
      lane_d = lane_q;
      if (clear_i) begin
         lane_d = '0;
      end else if (wr_en_i) begin
         lane_d[wr_idx_i] = wr_data_i;
      end
   end

   // Lane storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   assign vec_next_o = lane_d;

endmodule

// File: rtl/vector_wb_packer.sv
// Collects a lane-serial element stream into a full vector and issues a single
// one-cycle write to the vector register file. All outputs come straight from flops.
module vector_wb_packer
   import vrf_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   output logic                       start_ready_o,
   input  logic [REG_WIDTH-1:0]       rd_idx_i,
   input  logic [VL_WIDTH-1:0]        vl_i,
   input  logic                       elem_valid_i,
   input  logic [DATA_WIDTH-1:0]      elem_data_i,
   output logic                       elem_ready_o,
   output logic [REG_WIDTH-1:0]       rf_rd_o,
   output logic                       rf_wen_o,
   output logic [DATA_WIDTH*VMAX-1:0] rf_data_o,
   output logic                       done_o
);

   vwb_state_e                  state_q, state_d;
   logic [REG_WIDTH-1:0]        rd_q, rd_d;
   logic [VL_WIDTH-1:0]         vl_q, vl_d;
   logic [VL_WIDTH-1:0]         cnt_q, cnt_d;
   logic                        start_ready_q, start_ready_d;
   logic                        elem_ready_q, elem_ready_d;
   logic                        rf_wen_q, rf_wen_d;
   logic                        done_q, done_d;
   logic [REG_WIDTH-1:0]        rf_rd_q, rf_rd_d;
   logic [DATA_WIDTH*VMAX-1:0]  rf_data_q, rf_data_d;

   logic                        sh_clear;
   logic                        sh_wr_en;
   logic [DATA_WIDTH*VMAX-1:0]  sh_vec_next;
   logic [VL_WIDTH-1:0]         vl_eff;
   logic                        start_hs;
   logic                        elem_hs;

   assign vl_eff   = clamp_vl(vl_i);
   assign start_hs = start_i && start_ready_q;
   assign elem_hs  = elem_valid_i && elem_ready_q;

   vector_lane_shift_reg #(
      .DataWidth (DATA_WIDTH),
      .Lanes     (VMAX),
      .IdxWidth  (LANE_IDX_WIDTH)
   ) u_shadow (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (sh_clear),
      .wr_en_i    (sh_wr_en),
      .wr_idx_i   (cnt_q[LANE_IDX_WIDTH-1:0]),
      .wr_data_i  (elem_data_i),
      .vec_next_o (sh_vec_next)
   );

   // Next-state, job latching and lane-counter control.
   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      vl_d     = vl_q;
      cnt_d    = cnt_q;
      sh_clear = 1'b0;
      sh_wr_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_hs) begin
               rd_d     = rd_idx_i;
               vl_d     = vl_eff;
               cnt_d    = '0;
               sh_clear = 1'b1;
               state_d  = (vl_eff == '0) ? StWrite : StCollect;
            end
         end
         StCollect: begin
            if (elem_hs) begin
               sh_wr_en = 1'b1;
               cnt_d    = cnt_q + VL_WIDTH'(1);
               if (cnt_q == vl_q - VL_WIDTH'(1)) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output flops are loaded from the upcoming state so they line up with it.
   // Write index and data only change when entering WRITE and hold otherwise.
   always_comb begin
      start_ready_d = (state_d == StIdle);
      elem_ready_d  = (state_d == StCollect);
      done_d        = (state_d == StWrite);
      rf_wen_d      = (state_d == StWrite) && (rd_d != ZERO_REG);
      rf_rd_d       = rf_rd_q;
      rf_data_d     = rf_data_q;
      if (state_d == StWrite) begin
         rf_rd_d   = rd_d;
         rf_data_d = sh_vec_next;
      end
   end

   // State, job context and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         rd_q          <= '0;
         vl_q          <= '0;
         cnt_q         <= '0;
         start_ready_q <= 1'b1;
         elem_ready_q  <= 1'b0;
         rf_wen_q      <= 1'b0;
         done_q        <= 1'b0;
         rf_rd_q       <= '0;
         rf_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         rd_q          <= rd_d;
         vl_q          <= vl_d;
         cnt_q         <= cnt_d;
         start_ready_q <= start_ready_d;
         elem_ready_q  <= elem_ready_d;
         rf_wen_q      <= rf_wen_d;
         done_q        <= done_d;
         rf_rd_q       <= rf_rd_d;
         rf_data_q     <= rf_data_d;
      end
   end

   assign start_ready_o = start_ready_q;
   assign elem_ready_o  = elem_ready_q;
   assign rf_wen_o      = rf_wen_q;
   assign done_o        = done_q;
   assign rf_rd_o       = rf_rd_q;
   assign rf_data_o     = rf_data_q;

endmodule
